// File: rtl/flatten_buffer_if.sv
// Stream-in / vector-out bundle between the pooling stage, flatten_buffer and the dense layer.
interface flatten_buffer_if #(
   parameter int unsigned CH     = 32,
   parameter int unsigned H      = 7,
   parameter int unsigned W      = 7,
   parameter int unsigned DATA_W = 8
);
   localparam int unsigned IN_SIZE = CH * H * W;

   logic signed [DATA_W-1:0] in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic                     in_last;
   logic signed [DATA_W-1:0] out_vec [IN_SIZE];
   logic                     start;
   logic                     dense_done;
   logic                     busy;
   logic                     frame_err;

   // Upstream pooling stage plus dense layer side.
   modport master (
      output in_data, in_valid, in_last, dense_done,
      input  in_ready, out_vec, start, busy, frame_err
   );

   // The flatten buffer itself.
   modport slave (
      input  in_data, in_valid, in_last, dense_done,
      output in_ready, out_vec, start, busy, frame_err
   );
endinterface

// File: rtl/flatten_buffer.sv
// Ping-pong HWC-to-CHW reorder buffer feeding the first dense layer.
module flatten_buffer #(
   parameter int unsigned CH     = 32,
   parameter int unsigned H      = 7,
   parameter int unsigned W      = 7,
   parameter int unsigned DATA_W = 8
) (
   input logic            clk,
   input logic            rst_n,
   flatten_buffer_if.slave bus
);
   localparam int unsigned IN_SIZE = CH * H * W;
   localparam int unsigned AW      = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
   localparam int unsigned CW      = (CH > 1) ? $clog2(CH) : 1;
   localparam int unsigned RW      = (H > 1) ? $clog2(H) : 1;
   localparam int unsigned WW      = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [0:0] {StIdle, StRun} rd_state_e;

   logic signed [DATA_W-1:0] bank_q [2][IN_SIZE];
   logic [1:0]               full_q, full_d;
   logic                     wr_bank_q, wr_bank_d;
   logic                     rd_bank_q, rd_bank_d;
   logic [CW-1:0]            c_q, c_d;
   logic [WW-1:0]            col_q, col_d;
   logic [RW-1:0]            r_q, r_d;
   logic                     frame_err_q, frame_err_d;
   logic                     start_q, start_d;
   rd_state_e                state_q, state_d;

   logic          xfer;
   logic          last_elem;
   logic          rel_bank;
   logic [AW-1:0] addr;

   assign xfer      = bus.in_valid && bus.in_ready;
   assign last_elem = (c_q == CW'(CH - 1)) && (col_q == WW'(W - 1)) && (r_q == RW'(H - 1));
   assign rel_bank  = (state_q == StRun) && bus.dense_done;
   assign addr      = AW'(32'(c_q) * (H * W) + 32'(r_q) * W + 32'(col_q));

   assign bus.in_ready  = !full_q[wr_bank_q];
   assign bus.frame_err = frame_err_q;
   assign bus.start     = start_q;

   // Channel-fastest HWC counters; they wrap together after the final element.
   always_comb begin
      c_d   = c_q;
      col_d = col_q;
      r_d   = r_q;
      if (xfer) begin
         if (c_q == CW'(CH - 1)) begin
            c_d = '0;
            if (col_q == WW'(W - 1)) begin
               col_d = '0;
               r_d   = (r_q == RW'(H - 1)) ? '0 : r_q + RW'(1);
            end else begin
               col_d = col_q + WW'(1);
            end
         end else begin
            c_d = c_q + CW'(1);
         end
      end
   end

   // Bank ownership: writer marks a bank full, reader frees it. They never touch the same bank.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      if (xfer && last_elem) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
      end
      if (rel_bank) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
   end

   // Framing is by count; in_last is only cross-checked.
   always_comb begin
      frame_err_d = xfer && (bus.in_last != last_elem);
   end

   // Write-side and bookkeeping state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         c_q         <= '0;
         col_q       <= '0;
         r_q         <= '0;
         frame_err_q <= 1'b0;
      end else begin
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         c_q         <= c_d;
         col_q       <= col_d;
         r_q         <= r_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Bank storage; contents are don't-care until a bank is marked full, so no reset.
   always_ff @(posedge clk) begin
      if (xfer) begin
         bank_q[wr_bank_q][addr] <= bus.in_data;
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
      end
   end

   // Read FSM next state; dense_done outside StRun is ignored.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (full_q[rd_bank_q]) state_d = StRun;
         StRun:  if (bus.dense_done)    state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Read FSM outputs; start is registered so it lines up with the first StRun cycle.
   always_comb begin
      start_d  = (state_q == StIdle) && full_q[rd_bank_q];
      bus.busy = (state_q == StRun);
   end

   // The read bank only changes on release, so out_vec is stable for the whole run.
   always_comb begin
      for (int i = 0; i < int'(IN_SIZE); i++) begin
         bus.out_vec[i] = bank_q[rd_bank_q][i];
      end
   end
endmodule

// File: tb/tb_flatten_buffer.sv
// Directed/random bench: a tiny 2x2x2 instance for reorder, framing and reset, a default
// instance for ping-pong and backpressure.
module tb_flatten_buffer;
   localparam int S_CH = 2, S_H = 2, S_W = 2, S_SIZE = 8;
   localparam int B_CH = 32, B_H = 7, B_W = 7, B_SIZE = 1568;

   typedef logic signed [7:0] elem_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   flatten_buffer_if #(.CH(S_CH), .H(S_H), .W(S_W), .DATA_W(8)) sif ();
   flatten_buffer_if #(.CH(B_CH), .H(B_H), .W(B_W), .DATA_W(8)) bif ();

   flatten_buffer #(.CH(S_CH), .H(S_H), .W(S_W), .DATA_W(8)) u_small (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   flatten_buffer #(.CH(B_CH), .H(B_H), .W(B_W), .DATA_W(8)) u_big (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int rdy_drop = 0;
   int b_starts = 0;

   elem_t hwc[$], exp_s[$], vec_a[$], vec_b[$], vec_c[$], src_a[$], src_b[$], src_c[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: element (r, col, c) of an HWC stream belongs at position c, r, col of the CHW vector.
   task automatic flatten(input int ch, input int h, input int w, input elem_t src[$],
                          output elem_t dst[$]);
      dst = {};
      for (int c = 0; c < ch; c++)
         for (int r = 0; r < h; r++)
            for (int col = 0; col < w; col++)
               dst.push_back(src[(r * w + col) * ch + c]);
   endtask

   task automatic s_vec(input string tag, input elem_t exp[$]);
      int bad = 0;
      for (int i = 0; i < S_SIZE; i++) if (sif.out_vec[i] !== exp[i]) bad++;
      check(tag, bad, 0);
   endtask

   task automatic b_vec(input string tag, input elem_t exp[$]);
      int bad = 0;
      for (int i = 0; i < B_SIZE; i++) if (bif.out_vec[i] !== exp[i]) bad++;
      check(tag, bad, 0);
   endtask

   task automatic s_send(input elem_t d, input logic last, input logic exp_err, input string tag);
      sif.in_valid = 1'b1;
      sif.in_data  = d;
      sif.in_last  = last;
      check({tag, " in_ready"}, sif.in_ready, 1);
      step();
      check({tag, " frame_err"}, sif.frame_err, exp_err);
      sif.in_valid = 1'b0;
      sif.in_last  = 1'b0;
   endtask

   task automatic b_send(input elem_t d, input logic last);
      bif.in_valid = 1'b1;
      bif.in_data  = d;
      bif.in_last  = last;
      if (bif.in_ready !== 1'b1) rdy_drop++;
      step();
      if (bif.start === 1'b1) b_starts++;
      bif.in_valid = 1'b0;
      bif.in_last  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      sif.in_data = '0; sif.in_valid = 1'b0; sif.in_last = 1'b0; sif.dense_done = 1'b0;
      bif.in_data = '0; bif.in_valid = 1'b0; bif.in_last = 1'b0; bif.dense_done = 1'b0;
      rst_n = 1'b0;

      // Reset: transfers offered while in reset are ignored.
      sif.in_valid = 1'b1;
      repeat (3) step();
      check("rst s in_ready", sif.in_ready, 1);
      check("rst s start", sif.start, 0);
      check("rst s busy", sif.busy, 0);
      check("rst s frame_err", sif.frame_err, 0);
      check("rst b in_ready", bif.in_ready, 1);
      check("rst b busy", bif.busy, 0);
      sif.in_valid = 1'b0;
      rst_n = 1'b1;
      step();

      // HWC-to-CHW reorder of 0..7.
      hwc = {};
      for (int k = 0; k < S_SIZE; k++) hwc.push_back(elem_t'(k));
      flatten(S_CH, S_H, S_W, hwc, exp_s);
      for (int k = 0; k < S_SIZE; k++) s_send(hwc[k], k == S_SIZE - 1, 1'b0, "reorder");
      check("reorder start N+1", sif.start, 0);
      check("reorder in_ready N+1", sif.in_ready, 1);
      step();
      check("reorder start N+2", sif.start, 1);
      check("reorder busy N+2", sif.busy, 1);
      s_vec("reorder out_vec", exp_s);
      check("reorder exp[1]", 32'(exp_s[1]), 2);
      step();
      check("reorder start N+3", sif.start, 0);
      check("reorder busy N+3", sif.busy, 1);

      // Framing errors: early in_last on element 5, missing in_last on element 7.
      hwc = {};
      for (int k = 0; k < S_SIZE; k++) hwc.push_back(elem_t'($urandom));
      for (int k = 0; k < S_SIZE; k++) s_send(hwc[k], k == 5, (k == 5) || (k == 7), "framing");
      step();
      check("framing err single pulse", sif.frame_err, 0);
      check("both full in_ready", sif.in_ready, 0);
      s_vec("out_vec held in run", exp_s);
      flatten(S_CH, S_H, S_W, hwc, exp_s);
      sif.dense_done = 1'b1;
      step();
      sif.dense_done = 1'b0;
      check("release busy M+1", sif.busy, 0);
      check("release in_ready M+1", sif.in_ready, 1);
      check("release start M+1", sif.start, 0);
      step();
      check("framing start M+2", sif.start, 1);
      s_vec("framing out_vec", exp_s);

      // Release, then spurious dense_done in idle.
      sif.dense_done = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         check("spurious done busy", sif.busy, 0);
         check("spurious done start", sif.start, 0);
         check("spurious done in_ready", sif.in_ready, 1);
      end
      sif.dense_done = 1'b0;

      // Reset after a partial frame of three transfers.
      for (int k = 0; k < 3; k++) s_send(elem_t'($urandom), 1'b0, 1'b0, "partial");
      sif.dense_done = 1'b1;
      rst_n = 1'b0;
      #2;
      check("mid-frame rst start", sif.start, 0);
      check("mid-frame rst busy", sif.busy, 0);
      check("mid-frame rst in_ready", sif.in_ready, 1);
      step();
      rst_n = 1'b1;
      step();
      check("post-rst done ignored", sif.busy, 0);
      sif.dense_done = 1'b0;
      hwc = {};
      for (int k = 0; k < S_SIZE; k++) hwc.push_back(elem_t'($urandom));
      flatten(S_CH, S_H, S_W, hwc, exp_s);
      for (int k = 0; k < S_SIZE; k++) s_send(hwc[k], k == S_SIZE - 1, 1'b0, "post-rst");
      step();
      check("post-rst start", sif.start, 1);
      s_vec("post-rst out_vec", exp_s);

      // Ping-pong on the default geometry: A then B back to back, dense_done held low.
      check("big idle in_ready", bif.in_ready, 1);
      check("big idle busy", bif.busy, 0);
      for (int k = 0; k < B_SIZE; k++) begin
         src_a.push_back(elem_t'(k % 128));
         src_b.push_back(elem_t'(-(k % 128)));
         src_c.push_back(elem_t'($urandom));
      end
      flatten(B_CH, B_H, B_W, src_a, vec_a);
      flatten(B_CH, B_H, B_W, src_b, vec_b);
      flatten(B_CH, B_H, B_W, src_c, vec_c);
      for (int k = 0; k < B_SIZE; k++) b_send(src_a[k], k == B_SIZE - 1);
      for (int k = 0; k < B_SIZE; k++) b_send(src_b[k], k == B_SIZE - 1);
      check("pingpong ready never dropped", rdy_drop, 0);
      check("pingpong single start", b_starts, 1);
      check("pingpong in_ready after B", bif.in_ready, 0);
      check("pingpong busy", bif.busy, 1);
      check("pingpong no frame_err", bif.frame_err, 0);
      b_vec("pingpong out_vec A held", vec_a);

      // Backpressure: C[0] held while both banks are full.
      bif.in_valid = 1'b1;
      bif.in_data  = src_c[0];
      bif.in_last  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("stall in_ready", bif.in_ready, 0);
      end
      bif.dense_done = 1'b1;
      step();
      bif.dense_done = 1'b0;
      check("stall release busy", bif.busy, 0);
      check("stall release in_ready", bif.in_ready, 1);
      step();
      check("B start M+2", bif.start, 1);
      b_vec("B out_vec", vec_b);
      rdy_drop = 0;
      for (int k = 1; k < B_SIZE; k++) b_send(src_c[k], k == B_SIZE - 1);
      check("C ready never dropped", rdy_drop, 0);
      check("C both full in_ready", bif.in_ready, 0);
      bif.dense_done = 1'b1;
      step();
      bif.dense_done = 1'b0;
      check("C release in_ready", bif.in_ready, 1);
      step();
      check("C start", bif.start, 1);
      b_vec("C out_vec", vec_c);
      check("C element 0 at address 0", 32'(bif.out_vec[0]), 32'(src_c[0]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
